// File: rtl/arb_mux_pkg.sv
// Shared constants for the arbitrated output multiplexer: mode codes,
// arbitration state encodings and a small mode-decoding helper.
package arb_mux_pkg;

    // Selection mode codes as presented on the mode input
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;
    localparam logic [1:0] MODE_RR     = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Arbitration state: free to pick any channel, or locked to a packet owner
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // The reserved code behaves exactly like fixed priority
    function automatic logic is_fixed_mode(input logic [1:0] m);
        return (m == MODE_FIXED) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Rotating-priority arbiter: searches the request vector upward starting
// one past the pointer, wrapping at the top. Forcing the pointer to the
// highest index turns it into a plain lowest-index-wins priority encoder.
module arb_mux_rr_arbiter #(
    parameter int N_CH = 4,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // First requesting channel after the pointer wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated, registered multiplexer. Merges valid/ready producer
// channels onto one registered output stream using manual, fixed-priority or
// round-robin selection, and never interleaves beats of a multi-beat packet.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_CH       = 4,
    localparam int SEL_W     = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH-1:0]        in_last,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [0:0]            state;
    logic [SEL_W-1:0]      owner;
    logic [SEL_W-1:0]      rr_last;
    logic [SEL_W-1:0]      arb_ptr;
    logic [N_CH-1:0]       req;
    logic [N_CH-1:0]       grant;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  load;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    // Build the eligible request set and arbiter pointer from state and mode
    always_comb begin
        req     = '0;
        arb_ptr = rr_last;
        if (state == ST_LOCK) begin
            for (int k = 0; k < N_CH; k++) begin
                req[k] = in_valid[k] && (owner == SEL_W'(k));
            end
        end else if (mode == MODE_MANUAL) begin
            for (int k = 0; k < N_CH; k++) begin
                req[k] = in_valid[k] && (int'(sel) == k);
            end
        end else if (mode == MODE_RR) begin
            req = in_valid;
        end else if (is_fixed_mode(mode)) begin
            req     = in_valid;
            arb_ptr = SEL_W'(N_CH - 1);
        end
    end

    arb_mux_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arbiter (
        .req   (req),
        .ptr   (arb_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_valid)
    );

    assign load     = !out_valid || out_ready;
    assign transfer = load && grant_valid;
    assign in_ready = transfer ? grant : '0;
    assign sel_data = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last = in_last[grant_idx];

    // Output register: capture the granted beat, or drain when the sink takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_data  <= sel_data;
            out_ch    <= grant_idx;
            out_last  <= sel_last;
            out_valid <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

    // Packet lock and round-robin history, both advanced only by a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ARB;
            owner   <= '0;
            rr_last <= SEL_W'(N_CH - 1);
        end else if (transfer) begin
            rr_last <= grant_idx;
            if (state == ST_ARB && !sel_last) begin
                state <= ST_LOCK;
                owner <= grant_idx;
            end else if (state == ST_LOCK && sel_last) begin
                state <= ST_ARB;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios plus a long random run,
// all compared against a packet-level reference model of the arbitration rules.
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n;

    // Four-channel instance signals
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    // Three-channel instance signals
    logic [1:0]  mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_last3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_last3;
    logic        out_valid3;
    logic        out_ready3;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_locked;
    int m_owner;
    int m_rr_last;
    int m_out_valid;
    int m_out_data;
    int m_out_ch;
    int m_out_last;
    logic [3:0] last_in_ready;

    arb_mux #(.DATA_WIDTH(8), .N_CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    arb_mux #(.DATA_WIDTH(8), .N_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
        .in_ready(in_ready3), .out_data(out_data3), .out_ch(out_ch3),
        .out_last(out_last3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_locked    = 1'b0;
        m_owner     = 0;
        m_rr_last   = 3;
        m_out_valid = 0;
        m_out_data  = 0;
        m_out_ch    = 0;
        m_out_last  = 0;
    endtask

    // Which channel the rules allow this cycle, -1 if none
    function automatic int modelGrant();
        if (m_locked)
            return in_valid[m_owner] ? m_owner : -1;
        case (mode)
            2'b00: return in_valid[sel] ? int'(sel) : -1;
            2'b10: begin
                for (int i = 1; i <= 4; i++) begin
                    int c = (m_rr_last + i) % 4;
                    if (in_valid[c]) return c;
                end
                return -1;
            end
            default: begin
                for (int c = 0; c < 4; c++)
                    if (in_valid[c]) return c;
                return -1;
            end
        endcase
    endfunction

    // Drive one cycle of inputs, check ready before the edge and outputs after
    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s,
                                 input logic [3:0] v, input logic [3:0] l,
                                 input logic r);
        int g;
        bit ld;
        logic [3:0] exp_ready;
        mode = m; sel = s; in_valid = v; in_last = l; out_ready = r;
        #1;
        g  = modelGrant();
        ld = (m_out_valid == 0) || r;
        exp_ready = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        last_in_ready = in_ready;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_out_data  = int'(in_data[g*8 +: 8]);
                m_out_ch    = g;
                m_out_last  = int'(l[g]);
                m_out_valid = 1;
                m_rr_last   = g;
                if (m_locked && l[g]) m_locked = 1'b0;
                else if (!m_locked && !l[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end else begin
                m_out_valid = 0;
            end
        end
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_out_valid));
        checkOutput("out_data", 32'(out_data), 32'(m_out_data));
        checkOutput("out_ch", 32'(out_ch), 32'(m_out_ch));
        checkOutput("out_last", 32'(out_last), 32'(m_out_last));
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 2'b00; sel = 2'b00; in_valid = 4'b0; in_last = 4'b0; out_ready = 1'b1;
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode3 = 2'b00; sel3 = 2'b00; in_valid3 = 3'b0; in_last3 = 3'b0; out_ready3 = 1'b1;
        in_data3 = {8'hA2, 8'hA1, 8'hA0};
        modelReset();
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
        checkOutput("rst_out_valid3", 32'(out_valid3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three-channel manual selection, including an out-of-range select
        mode3 = 2'b00; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111;
        #1;
        checkOutput("t6_ready_sel3", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        checkOutput("t6_valid_sel3", 32'(out_valid3), 32'd0);
        sel3 = 2'd1;
        #1;
        checkOutput("t6_ready_sel1", 32'(in_ready3), 32'b010);
        @(posedge clk); #1;
        checkOutput("t6_valid_sel1", 32'(out_valid3), 32'd1);
        checkOutput("t6_ch_sel1", 32'(out_ch3), 32'd1);
        checkOutput("t6_data_sel1", 32'(out_data3), 32'hA1);
        in_valid3 = 3'b000;

        // Round-robin across all channels, single-beat packets
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b10, 2'b00, 4'hF, 4'hF, 1'b1);
            checkOutput("t2_ch", 32'(out_ch), 32'(i % 4));
            checkOutput("t2_data", 32'(out_data), 32'hA0 + 32'(i % 4));
        end

        // Sink stall holds the output and blocks every channel
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 2'b00, 4'hF, 4'hF, 1'b0);
            checkOutput("t4_hold_ready", 32'(last_in_ready), 32'd0);
            checkOutput("t4_hold_ch", 32'(out_ch), 32'd0);
            checkOutput("t4_hold_data", 32'(out_data), 32'hA0);
        end
        applyStimulus(2'b10, 2'b00, 4'hF, 4'hF, 1'b1);
        checkOutput("t4_release_ch", 32'(out_ch), 32'd1);
        checkOutput("t4_release_data", 32'(out_data), 32'hA1);

        // Fixed priority never reaches the higher channel
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 2'b00, 4'b1010, 4'hF, 1'b1);
            checkOutput("t3_ready", 32'(last_in_ready), 32'b0010);
            checkOutput("t3_ch", 32'(out_ch), 32'd1);
        end

        // Asynchronous reset between edges while a beat is held
        #2;
        checkOutput("t1_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_data", 32'(out_data), 32'd0);
        checkOutput("t1_ch", 32'(out_ch), 32'd0);
        checkOutput("t1_last", 32'(out_last), 32'd0);
        modelReset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Packet lock survives a competing channel and mode changes
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        applyStimulus(2'b01, 2'b00, 4'b0100, 4'b0000, 1'b1);
        checkOutput("t5_beat1", 32'(out_ch), 32'd2);
        applyStimulus(2'b00, 2'b00, 4'b0101, 4'b0000, 1'b1);
        checkOutput("t5_beat2", 32'(out_ch), 32'd2);
        applyStimulus(2'b10, 2'b00, 4'b0101, 4'b0100, 1'b1);
        checkOutput("t5_beat3", 32'(out_ch), 32'd2);
        checkOutput("t5_beat3_last", 32'(out_last), 32'd1);
        applyStimulus(2'b01, 2'b00, 4'b0101, 4'b0100, 1'b1);
        checkOutput("t5_after", 32'(out_ch), 32'd0);

        // Long random run against the reference model
        begin
            logic [1:0] r_mode = 2'b10;
            for (int n = 0; n < 1500; n++) begin
                logic [3:0] l;
                if ($urandom_range(0, 15) == 0) r_mode = 2'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) l[k] = ($urandom_range(0, 2) != 0);
                in_data = $urandom;
                applyStimulus(r_mode, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                              l, ($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
